// File: rtl/stream_compare_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_compare_multi_pkg
// Purpose  : Shared types and helpers for the multi-lane stream comparator.
// Revision : 1.0 - initial release
// ============================================================================
package stream_compare_multi_pkg;

    localparam int c_MAX_LINKS      = 16;
    localparam int c_MAX_LINK_WIDTH = 64;
    localparam int c_MAX_DATA       = c_MAX_LINKS * c_MAX_LINK_WIDTH;
    localparam int c_MAX_CNT_WIDTH  = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        CAPTURED = 2'd2
    } cap_state_t;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [c_MAX_CNT_WIDTH-1:0] sat_inc(
        input logic [c_MAX_CNT_WIDTH-1:0] value,
        input int unsigned                width
    );
        logic [c_MAX_CNT_WIDTH-1:0] limit;
        limit = (width >= c_MAX_CNT_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= limit) ? limit : value + 64'd1;
    endfunction

    // One bit per lane: set when the lane is enabled and its data differs.
    function automatic logic [c_MAX_LINKS-1:0] lane_mismatch_mask(
        input logic [c_MAX_DATA-1:0]  data0,
        input logic [c_MAX_DATA-1:0]  data1,
        input logic [c_MAX_LINKS-1:0] active,
        input int unsigned            nlinks,
        input int unsigned            lane_width
    );
        logic [c_MAX_LINKS-1:0] mask;
        logic [9:0]             idx;
        mask = '0;
        for (int unsigned l = 0; l < c_MAX_LINKS; l++) begin
            for (int unsigned b = 0; b < c_MAX_LINK_WIDTH; b++) begin
                idx = 10'(l * lane_width + b);
                if (l < nlinks && b < lane_width && active[l] && (data0[idx] != data1[idx]))
                    mask[l] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_skew_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sc_skew_fifo
// Purpose  : Shift-register FIFO whose head is always entry 0, with flush.
// Revision : 1.0 - initial release
// ============================================================================
module sc_skew_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;
    logic [c_AW-1:0]  w_wr_idx;

    assign o_full   = (r_count == c_CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_ready  = ~o_full & ~areset;
    assign o_head   = r_mem[0];
    assign w_push   = i_valid & o_ready;
    assign w_pop    = i_pop & ~o_empty;
    // A simultaneous pop shifts everything down one slot, so the new beat lands one lower.
    assign w_wr_idx = w_pop ? c_AW'(r_count - 1'b1) : c_AW'(r_count);

    always_ff @(posedge clk) begin
        if (areset || i_flush) begin
            r_count <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++)
                    r_mem[i] <= r_mem[i+1];
            end
            if (w_push)
                r_mem[w_wr_idx] <= i_data;
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_compare_multi.sv
`default_nettype none
// ============================================================================
// Module   : stream_compare_multi
// Purpose  : Lane-wise comparator of two skewed streams with saturating counters.
// Options  : STREAM_COMPARE_MULTI_CAPTURE_EN builds the first-mismatch capture.
// Revision : 1.0 - initial release
// ============================================================================
module stream_compare_multi
    import stream_compare_multi_pkg::*;
#(
    parameter int NLINKS     = 4,
    parameter int LINK_WIDTH = 32,
    parameter int SKEW_DEPTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic [NLINKS*LINK_WIDTH-1:0] s0_tdata,
    input  logic                         s0_tvalid,
    output logic                         s0_tready,
    input  logic [NLINKS*LINK_WIDTH-1:0] s1_tdata,
    input  logic                         s1_tvalid,
    output logic                         s1_tready,
    input  logic [NLINKS-1:0]            active_links,
    input  logic                         clear,
    input  logic                         latch,
    input  logic                         trigger_en,
    input  logic                         arm,
    output logic                         mismatch,
    output logic [CNT_WIDTH-1:0]         word_count_snap,
    output logic [NLINKS*CNT_WIDTH-1:0]  err_count_snap,
    output logic                         cap_valid,
    output logic [CNT_WIDTH-1:0]         cap_index,
    output logic [NLINKS-1:0]            cap_lanes,
    output logic [NLINKS*LINK_WIDTH-1:0] cap_data0,
    output logic [NLINKS*LINK_WIDTH-1:0] cap_data1
);
    localparam int c_DW = NLINKS * LINK_WIDTH;

    logic [c_DW-1:0]      w_head0;
    logic [c_DW-1:0]      w_head1;
    logic                 w_empty0;
    logic                 w_empty1;
    logic                 w_full0;
    logic                 w_full1;
    logic                 w_event;
    logic [NLINKS-1:0]    w_lane_err;
    logic                 w_any_err;

    logic [CNT_WIDTH-1:0] r_word_count;
    logic [CNT_WIDTH-1:0] r_err_count [NLINKS];
    logic                 r_mismatch;
    logic [CNT_WIDTH-1:0] r_word_snap;
    logic [NLINKS*CNT_WIDTH-1:0] r_err_snap;

    sc_skew_fifo #(.WIDTH(c_DW), .DEPTH(SKEW_DEPTH)) u_fifo0 (
        .clk     (clk),
        .areset  (areset),
        .i_flush (clear),
        .i_valid (s0_tvalid),
        .i_data  (s0_tdata),
        .o_ready (s0_tready),
        .i_pop   (w_event),
        .o_head  (w_head0),
        .o_empty (w_empty0),
        .o_full  (w_full0)
    );

    sc_skew_fifo #(.WIDTH(c_DW), .DEPTH(SKEW_DEPTH)) u_fifo1 (
        .clk     (clk),
        .areset  (areset),
        .i_flush (clear),
        .i_valid (s1_tvalid),
        .i_data  (s1_tdata),
        .o_ready (s1_tready),
        .i_pop   (w_event),
        .o_head  (w_head1),
        .o_empty (w_empty1),
        .o_full  (w_full1)
    );

    logic w_unused_full;
    assign w_unused_full = w_full0 ^ w_full1;

    assign w_event    = ~w_empty0 & ~w_empty1;
    assign w_lane_err = w_event ? NLINKS'(lane_mismatch_mask(c_MAX_DATA'(w_head0), c_MAX_DATA'(w_head1),
                                                            c_MAX_LINKS'(active_links), NLINKS, LINK_WIDTH))
                                : '0;
    assign w_any_err  = |w_lane_err;

    // Snapshot samples the registers before this edge, so latch+clear keeps pre-clear values.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_word_count <= '0;
            for (int i = 0; i < NLINKS; i++)
                r_err_count[i] <= '0;
            r_mismatch  <= 1'b0;
            r_word_snap <= '0;
            r_err_snap  <= '0;
        end else begin
            if (latch) begin
                r_word_snap <= r_word_count;
                for (int i = 0; i < NLINKS; i++)
                    r_err_snap[i*CNT_WIDTH +: CNT_WIDTH] <= r_err_count[i];
            end
            r_mismatch <= w_any_err & trigger_en & ~clear;
            if (clear) begin
                r_word_count <= '0;
                for (int i = 0; i < NLINKS; i++)
                    r_err_count[i] <= '0;
            end else if (w_event) begin
                r_word_count <= CNT_WIDTH'(sat_inc(c_MAX_CNT_WIDTH'(r_word_count), CNT_WIDTH));
                for (int i = 0; i < NLINKS; i++) begin
                    if (w_lane_err[i])
                        r_err_count[i] <= CNT_WIDTH'(sat_inc(c_MAX_CNT_WIDTH'(r_err_count[i]), CNT_WIDTH));
                end
            end
        end
    end

    assign mismatch        = r_mismatch;
    assign word_count_snap = r_word_snap;
    assign err_count_snap  = r_err_snap;

`ifdef STREAM_COMPARE_MULTI_CAPTURE_EN
    cap_state_t           r_state;
    logic                 r_cap_valid;
    logic [CNT_WIDTH-1:0] r_cap_index;
    logic [NLINKS-1:0]    r_cap_lanes;
    logic [c_DW-1:0]      r_cap_data0;
    logic [c_DW-1:0]      r_cap_data1;

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cap_valid <= 1'b0;
            r_cap_index <= '0;
            r_cap_lanes <= '0;
            r_cap_data0 <= '0;
            r_cap_data1 <= '0;
        end else if (clear) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_state     <= ARMED;
                        r_cap_valid <= 1'b0;
                    end
                end
                ARMED: begin
                    if (w_any_err) begin
                        r_state     <= CAPTURED;
                        r_cap_valid <= 1'b1;
                        r_cap_index <= r_word_count;
                        r_cap_lanes <= w_lane_err;
                        r_cap_data0 <= w_head0;
                        r_cap_data1 <= w_head1;
                    end
                end
                CAPTURED: begin
                    if (arm) begin
                        r_state     <= ARMED;
                        r_cap_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cap_valid = r_cap_valid;
    assign cap_index = r_cap_index;
    assign cap_lanes = r_cap_lanes;
    assign cap_data0 = r_cap_data0;
    assign cap_data1 = r_cap_data1;
`else
    logic w_unused_arm;
    assign w_unused_arm = arm;

    assign cap_valid = 1'b0;
    assign cap_index = '0;
    assign cap_lanes = '0;
    assign cap_data0 = '0;
    assign cap_data1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_compare_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_compare_multi
// Purpose  : Directed bench with a queue-based reference model for the comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_compare_multi;
    localparam int NL  = 4;
    localparam int LW  = 32;
    localparam int DEP = 8;
    localparam int DW  = NL * LW;
`ifdef STREAM_COMPARE_MULTI_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic [NL-1:0] active_links = 4'hF;
    logic clear = 1'b0, latch = 1'b0, trigger_en = 1'b1, arm = 1'b0;

    logic a_s0_tready, a_s1_tready, a_mismatch, a_cap_valid;
    logic [31:0] a_word_snap, a_cap_index;
    logic [NL*32-1:0] a_err_snap;
    logic [NL-1:0] a_cap_lanes;
    logic [DW-1:0] a_cap_data0, a_cap_data1;

    logic b_s0_tready, b_s1_tready, b_mismatch, b_cap_valid;
    logic [3:0] b_word_snap, b_cap_index;
    logic [NL*4-1:0] b_err_snap;
    logic [NL-1:0] b_cap_lanes;
    logic [DW-1:0] b_cap_data0, b_cap_data1;

    stream_compare_multi #(.NLINKS(NL), .LINK_WIDTH(LW), .SKEW_DEPTH(DEP), .CNT_WIDTH(32)) u_dut_a (
        .clk(clk), .areset(areset),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(a_s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(a_s1_tready),
        .active_links(active_links), .clear(clear), .latch(latch),
        .trigger_en(trigger_en), .arm(arm), .mismatch(a_mismatch),
        .word_count_snap(a_word_snap), .err_count_snap(a_err_snap),
        .cap_valid(a_cap_valid), .cap_index(a_cap_index), .cap_lanes(a_cap_lanes),
        .cap_data0(a_cap_data0), .cap_data1(a_cap_data1)
    );

    stream_compare_multi #(.NLINKS(NL), .LINK_WIDTH(LW), .SKEW_DEPTH(DEP), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .areset(areset),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(b_s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(b_s1_tready),
        .active_links(active_links), .clear(clear), .latch(latch),
        .trigger_en(trigger_en), .arm(arm), .mismatch(b_mismatch),
        .word_count_snap(b_word_snap), .err_count_snap(b_err_snap),
        .cap_valid(b_cap_valid), .cap_index(b_cap_index), .cap_lanes(b_cap_lanes),
        .cap_data0(b_cap_data0), .cap_data1(b_cap_data1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, counters as saturating integers.
    logic [DW-1:0]   q0[$];
    logic [DW-1:0]   q1[$];
    longint unsigned m_wc_a, m_wc_b, m_wsnap_a, m_wsnap_b;
    longint unsigned m_err_a[NL], m_err_b[NL], m_esnap_a[NL], m_esnap_b[NL];
    logic            m_mis;
    int              m_cap_st;
    logic            m_cap_valid;
    longint unsigned m_cap_idx_a, m_cap_idx_b;
    logic [NL-1:0]   m_cap_lanes;
    logic [DW-1:0]   m_cap_d0, m_cap_d1;

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    initial begin : model
        logic          ev, acc0, acc1;
        logic [NL-1:0] m;
        forever begin
            @(posedge clk);
            if (areset) begin
                q0.delete(); q1.delete();
                m_wc_a = 0; m_wc_b = 0; m_wsnap_a = 0; m_wsnap_b = 0;
                for (int l = 0; l < NL; l++) begin
                    m_err_a[l] = 0; m_err_b[l] = 0; m_esnap_a[l] = 0; m_esnap_b[l] = 0;
                end
                m_mis = 1'b0; m_cap_st = 0; m_cap_valid = 1'b0;
                m_cap_idx_a = 0; m_cap_idx_b = 0; m_cap_lanes = '0; m_cap_d0 = '0; m_cap_d1 = '0;
            end else begin
                ev = (q0.size() > 0) && (q1.size() > 0);
                m  = '0;
                if (ev)
                    for (int l = 0; l < NL; l++)
                        if (active_links[l] && (q0[0][l*LW +: LW] != q1[0][l*LW +: LW])) m[l] = 1'b1;
                acc0 = s0_tvalid && (q0.size() < DEP);
                acc1 = s1_tvalid && (q1.size() < DEP);
                if (latch) begin
                    m_wsnap_a = m_wc_a; m_wsnap_b = m_wc_b;
                    for (int l = 0; l < NL; l++) begin
                        m_esnap_a[l] = m_err_a[l]; m_esnap_b[l] = m_err_b[l];
                    end
                end
                m_mis = ev && (m != '0) && trigger_en && !clear;
                if (clear) begin
                    q0.delete(); q1.delete();
                    m_wc_a = 0; m_wc_b = 0;
                    for (int l = 0; l < NL; l++) begin
                        m_err_a[l] = 0; m_err_b[l] = 0;
                    end
                    m_cap_st = 0;
                end else begin
                    if (CAP_EN && m_cap_st == 1 && m != '0) begin
                        m_cap_st = 2; m_cap_valid = 1'b1;
                        m_cap_idx_a = m_wc_a; m_cap_idx_b = m_wc_b;
                        m_cap_lanes = m; m_cap_d0 = q0[0]; m_cap_d1 = q1[0];
                    end else if (CAP_EN && arm) begin
                        m_cap_st = 1; m_cap_valid = 1'b0;
                    end
                    if (ev) begin
                        m_wc_a = sat(m_wc_a, 64'hFFFF_FFFF);
                        m_wc_b = sat(m_wc_b, 64'd15);
                        for (int l = 0; l < NL; l++)
                            if (m[l]) begin
                                m_err_a[l] = sat(m_err_a[l], 64'hFFFF_FFFF);
                                m_err_b[l] = sat(m_err_b[l], 64'd15);
                            end
                        void'(q0.pop_front());
                        void'(q1.pop_front());
                    end
                    if (acc0) q0.push_back(s0_tdata);
                    if (acc1) q1.push_back(s1_tdata);
                end
            end
        end
    end

    initial begin : compare
        logic [NL*32-1:0] ea;
        logic [NL*4-1:0]  eb;
        logic             r0, r1;
        forever begin
            @(negedge clk);
            r0 = !areset && (q0.size() < DEP);
            r1 = !areset && (q1.size() < DEP);
            for (int l = 0; l < NL; l++) begin
                ea[l*32 +: 32] = 32'(m_esnap_a[l]);
                eb[l*4 +: 4]   = 4'(m_esnap_b[l]);
            end
            if (a_mismatch === 1'b1) n_pulses++;
            check("a_s0_tready", 128'(a_s0_tready), 128'(r0));
            check("a_s1_tready", 128'(a_s1_tready), 128'(r1));
            check("b_s0_tready", 128'(b_s0_tready), 128'(r0));
            check("a_mismatch",  128'(a_mismatch),  128'(m_mis));
            check("b_mismatch",  128'(b_mismatch),  128'(m_mis));
            check("a_word_snap", 128'(a_word_snap), 128'(m_wsnap_a));
            check("b_word_snap", 128'(b_word_snap), 128'(m_wsnap_b));
            check("a_err_snap",  128'(a_err_snap),  128'(ea));
            check("b_err_snap",  128'(b_err_snap),  128'(eb));
            check("a_cap_valid", 128'(a_cap_valid), 128'(m_cap_valid));
            check("a_cap_index", 128'(a_cap_index), 128'(m_cap_idx_a));
            check("a_cap_lanes", 128'(a_cap_lanes), 128'(m_cap_lanes));
            check("a_cap_data0", 128'(a_cap_data0), 128'(m_cap_d0));
            check("a_cap_data1", 128'(a_cap_data1), 128'(m_cap_d1));
            check("b_cap_valid", 128'(b_cap_valid), 128'(m_cap_valid));
            check("b_cap_index", 128'(b_cap_index), 128'(m_cap_idx_b));
        end
    end

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*LW +: LW] = 32'(k * 131 + l * 7919) ^ 32'hA5C3_0F1E;
        return v;
    endfunction

    function automatic logic [DW-1:0] flipv(input int k, input int fw, input bit fall, input int fl);
        logic [DW-1:0] v;
        v = '0;
        if (fall || k == fw) v[fl*LW +: LW] = 32'h0000_0100;
        return v;
    endfunction

    bit stalled;

    task automatic drive_streams(input int nwords, input int skew, input int fw, input bit fall, input int fl);
        int  p0, p1, cyc;
        bit  a0, a1;
        p0 = 0; p1 = 0; cyc = 0; stalled = 0;
        while ((p0 < nwords || p1 < nwords) && cyc < 1000) begin
            s0_tvalid = (p0 < nwords);
            s0_tdata  = pat(p0);
            s1_tvalid = (cyc >= skew) && (p1 < nwords);
            s1_tdata  = pat(p1) ^ flipv(p1, fw, fall, fl);
            @(negedge clk);
            a0 = s0_tvalid && a_s0_tready;
            a1 = s1_tvalid && a_s1_tready;
            if (s0_tvalid && !a_s0_tready) stalled = 1;
            @(posedge clk); #2;
            p0 += int'(a0); p1 += int'(a1); cyc++;
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        check("stream_drained", 128'(cyc < 1000), 128'(1));
        repeat (3) @(posedge clk);
        #2 latch = 1'b1;
        @(posedge clk); #2 latch = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_phase(input int nwords, input int skew, input int fw, input bit fall, input int fl,
                             input logic [NL-1:0] act);
        active_links = act;
        clear = 1'b1;
        @(posedge clk); #2 clear = 1'b0; arm = 1'b1;
        @(posedge clk); #2 arm = 1'b0;
        n_pulses = 0;
        drive_streams(nwords, skew, fw, fall, fl);
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #2 areset = 1'b0;
        @(negedge clk);
        check("reset_tready",    128'(a_s0_tready), 128'(1));
        check("reset_word_snap", 128'(a_word_snap), 128'(0));
        check("reset_cap_valid", 128'(a_cap_valid), 128'(0));
        check("reset_mismatch",  128'(a_mismatch),  128'(0));
        @(posedge clk); #2;

        run_phase(100, 0, -1, 1'b0, 0, 4'hF);
        check("p1_word",   128'(a_word_snap), 128'(100));
        check("p1_err",    128'(a_err_snap),  128'(0));
        check("p1_pulses", 128'(n_pulses),    128'(0));
        check("p1_b_word", 128'(b_word_snap), 128'(15));

        run_phase(100, 0, 10, 1'b0, 2, 4'hF);
        check("p2_word",      128'(a_word_snap),         128'(100));
        check("p2_err2",      128'(a_err_snap[95:64]),   128'(1));
        check("p2_err_other", 128'({a_err_snap[127:96], a_err_snap[63:0]}), 128'(0));
        check("p2_pulses",    128'(n_pulses),            128'(1));
        check("p2_cap_valid", 128'(a_cap_valid), 128'(CAP_EN));
        check("p2_cap_index", 128'(a_cap_index), CAP_EN ? 128'(10) : 128'(0));
        check("p2_cap_lanes", 128'(a_cap_lanes), CAP_EN ? 128'(4'b0100) : 128'(0));
        check("p2_cap_data0", 128'(a_cap_data0), CAP_EN ? 128'(pat(10)) : 128'(0));
        check("p2_cap_data1", 128'(a_cap_data1), CAP_EN ? 128'(pat(10) ^ flipv(10, 10, 1'b0, 2)) : 128'(0));

        run_phase(100, 0, 10, 1'b0, 2, 4'b1011);
        check("p3_err",       128'(a_err_snap),  128'(0));
        check("p3_pulses",    128'(n_pulses),    128'(0));
        check("p3_cap_valid", 128'(a_cap_valid), 128'(0));

        run_phase(100, 8, -1, 1'b0, 0, 4'hF);
        check("p4_word", 128'(a_word_snap), 128'(100));
        check("p4_err",  128'(a_err_snap),  128'(0));

        run_phase(100, 12, -1, 1'b0, 0, 4'hF);
        check("p5_stall", 128'(stalled),     128'(1));
        check("p5_word",  128'(a_word_snap), 128'(100));
        check("p5_err",   128'(a_err_snap),  128'(0));

        run_phase(20, 0, -1, 1'b1, 1, 4'hF);
        check("p6_a_word",  128'(a_word_snap),        128'(20));
        check("p6_a_err1",  128'(a_err_snap[63:32]),  128'(20));
        check("p6_b_word",  128'(b_word_snap),        128'(15));
        check("p6_b_err",   128'(b_err_snap),         128'(16'h00F0));
        check("p6_pulses",  128'(n_pulses),           128'(20));

        // Clear lands on a cycle where both FIFOs hold a mismatching pair.
        for (int k = 0; k < 6; k++) begin
            s0_tvalid = 1'b1; s1_tvalid = 1'b1;
            s0_tdata  = pat(k);
            s1_tdata  = pat(k) ^ flipv(k, -1, 1'b1, 0);
            @(posedge clk); #2;
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; clear = 1'b1;
        @(posedge clk); #2 clear = 1'b0; latch = 1'b1;
        @(negedge clk);
        check("p7_mismatch_on_clear", 128'(a_mismatch), 128'(0));
        @(posedge clk); #2 latch = 1'b0;
        @(negedge clk);
        check("p7_word_after_clear", 128'(a_word_snap), 128'(0));
        check("p7_err_after_clear",  128'(a_err_snap),  128'(0));
        @(posedge clk); #2;
        drive_streams(5, 0, 2, 1'b0, 3);
        check("p7_word", 128'(a_word_snap),         128'(5));
        check("p7_err3", 128'(a_err_snap[127:96]),  128'(1));
        check("p7_cap_index_held", 128'(a_cap_index), 128'(0));

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_compare_multi.md
# stream_compare_multi

Multi-link stream comparator for link-integrity testing. Two AXI-Stream inputs carry NLINKS parallel lanes each. Each input passes through a small skew-absorbing FIFO, and the lanes are compared word-for-word. The block keeps saturating per-lane error counters and a global word counter, snapshots them on request, and can capture the first mismatching word pair. It sits after the link receivers; a separate IPIF wrapper maps its control and status ports to registers.

## Interface
- NLINKS, 4, number of lanes per stream (1–16)
- LINK_WIDTH, 32, bits per lane
- SKEW_DEPTH, 8, entries per input FIFO (power of two, ≥2)
- CNT_WIDTH, 32, counter width
- clk  in  1  block clock
- areset  in  1  reset, synchronous, active-high
- s0_tdata  in  NLINKS*LINK_WIDTH  stream 0 data; lane i is bits [i*LINK_WIDTH +: LINK_WIDTH]
- s0_tvalid / s0_tready  in / out  1  stream 0 handshake
- s1_tdata, s1_tvalid, s1_tready  as stream 0
- active_links  in  NLINKS  per-lane compare enable; a 0 lane is never counted as an error
- clear  in  1  pulse: zero all counters, flush both FIFOs
- latch  in  1  pulse: snapshot counters into the *_snap outputs
- trigger_en  in  1  enables the mismatch output pulse
- arm  in  1  pulse: arm first-mismatch capture
- mismatch  out  1  registered pulse, one cycle per mismatching compare
- word_count_snap  out  CNT_WIDTH  snapshot of compared-word count
- err_count_snap  out  NLINKS*CNT_WIDTH  per-lane error-count snapshot
- cap_valid  out  1  capture register holds data
- cap_index  out  CNT_WIDTH  word index of the captured mismatch
- cap_lanes  out  NLINKS  mismatching-lane mask of the captured word
- cap_data0 / cap_data1  out  NLINKS*LINK_WIDTH  captured word pair

## Operation
- **FIFO input:** each input writes into its own FIFO. tready = !full, with no dependency on tvalid. An accepted beat is readable at the FIFO head the next cycle.
- **Compare event:** fires when both FIFOs are non-empty. Both heads pop in the same cycle; one word is counted per event.
- **Lane error:** lane i errs when active_links[i] is set and its lane data differs between the two heads.
- **Counters:**
  - word_count increments by 1 per compare event.
  - err_count[i] increments by 1 per compare event in which lane i errs.
  - All counters saturate at all-ones and never wrap.
- **mismatch:** asserted the cycle after a compare event with any lane error, when trigger_en is high.
- **Snapshots:** on latch, the *_snap outputs load the live counter values as they stand before this cycle's update. They hold until the next latch.
- **Capture FSM** (states IDLE, ARMED, CAPTURED):
  - IDLE → ARMED on arm; cap_valid is cleared.
  - ARMED → CAPTURED on the first compare event with any lane error. That event loads the capture registers: cap_index takes the pre-increment word_count, cap_lanes takes the erring-lane mask, cap_data0/1 take the two heads. cap_valid is set.
  - CAPTURED → ARMED on arm.
  - Any state → IDLE on clear.
  - In CAPTURED, further mismatches do not change the capture registers.
- **Simultaneous events:**
  - clear with a compare event: clear wins; counters become 0 and the popped pair is discarded.
  - latch with clear: the snapshot takes the pre-clear values.
  - arm with clear: clear wins.

## Timing
- Reset values (areset):
  - all counters, snapshots and capture registers 0
  - cap_valid 0, FSM in IDLE
  - mismatch 0
  - FIFOs empty
  - tready 0 during reset, 1 in the first cycle after reset.
- Latency from input acceptance to the compare pop is 1 cycle minimum, when the other FIFO already holds data.
- Latency from pop to mismatch, counter update and capture is 1 cycle.
- A full FIFO holds tready low until a pop. Sustained throughput with no skew is 1 word per cycle.
- Maximum absorbed skew between the streams is SKEW_DEPTH beats. Larger skew back-pressures the leading stream and loses no data.
- Changing active_links takes effect on the next compare event.

## Configuration
- Macro STREAM_COMPARE_MULTI_CAPTURE_EN.
  - Defined: the capture FSM and capture registers are built; arm is honoured.
  - Undefined: the FSM and capture registers are not instantiated; cap_* outputs are tied to 0 and arm is ignored. Counting and mismatch behaviour are unchanged.

## Structure
- Package stream_compare_multi_pkg holds:
  - the capture-state enum (IDLE, ARMED, CAPTURED)
  - a saturating-increment function, parameterised by width
  - a lane-mismatch-mask function.
- Sub-module sc_skew_fifo: synchronous FIFO of depth SKEW_DEPTH with registered head, full/empty flags and flush. It is instantiated once per input.

## Test plan
- NLINKS=4, identical 100-word streams, all lanes active → word_count_snap=100 after latch; all err_count_snap lanes 0; mismatch never asserted.
- Word 10 has lane 2 flipped, trigger_en=1, armed → one mismatch pulse; err_count[2]=1; cap_index=10; cap_lanes=4'b0100; cap_data0/1 equal the injected pair.
- Same stimulus with active_links=4'b1011 → err_count all 0; no mismatch pulse; cap_valid=0.
- Stream 1 delayed 8 beats with SKEW_DEPTH=8 → no data lost, 0 errors. Delayed 12 beats → s0_tready drops low, still 0 errors and word_count correct.
- CNT_WIDTH=4, 20 mismatching words → err_count saturates at 15 and word_count at 15.
- clear asserted in the same cycle as a compare event → counters 0 next cycle; FSM IDLE; FIFOs empty.
